// File: rtl/freq_bcd_converter_if.sv
// Start/Busy/Done handshake bundle between the frequency counter,
// the binary-to-BCD converter and the seven-segment display driver.
interface freq_bcd_converter_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic                  Start;
  logic [WIDTH-1:0]      Freq;
  logic                  Busy;
  logic                  Done;
  logic [4*DIGITS-1:0]   Bcd;
  logic [DIGITS-1:0]     Blank;

  modport master (
    output Start,
    output Freq,
    input  Busy,
    input  Done,
    input  Bcd,
    input  Blank
  );

  modport slave (
    input  Start,
    input  Freq,
    output Busy,
    output Done,
    output Bcd,
    output Blank
  );
endinterface

// File: rtl/freq_bcd_converter.sv
// Sequential double-dabble converter: one Freq bit per clock into packed
// BCD, plus a leading-zero blank mask for the display driver.
module freq_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  freq_bcd_converter_if.slave   bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sh;
  logic [BW-1:0]     scr;
  logic [CW-1:0]     cnt;
  logic              busy_q;
  logic              done_q;
  logic [BW-1:0]     bcd_q;
  logic [DIGITS-1:0] blank_q;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     scr_nx;
  logic [WIDTH-1:0]  sh_nx;
  logic [DIGITS-1:0] mask_nx;
  logic              zr;

  // Digits never exceed 9 before correction, so add-3 cannot carry out.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = scr[4*i +: 4];
    end
  end

  assign scr_nx = {adj[BW-2:0], sh[WIDTH-1]};
  assign sh_nx  = sh << 1;

  // Mask is computed from the post-shift value so it lands with Bcd.
  always_comb begin
    mask_nx = '0;
    zr      = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zr         = zr & (scr_nx[4*i +: 4] == 4'd0);
      mask_nx[i] = zr;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      sh      <= '0;
      scr     <= '0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            sh     <= bus.Freq;
            scr    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sh  <= sh_nx;
          scr <= scr_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            bcd_q   <= scr_nx;
            blank_q <= mask_nx;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.Bcd   = bcd_q;
  assign bus.Blank = blank_q;

endmodule

// File: tb/tb_freq_bcd_converter.sv
// Directed plus random checks of the BCD converter against a decimal
// reference model built from division and powers of ten.
module tb_freq_bcd_converter;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  logic Clk;
  logic Reset_n;
  int   vectors;
  int   miscompares;

  freq_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  freq_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [39:0] ref_bcd(input longint unsigned v);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [9:0] ref_blank(input longint unsigned v);
    logic [9:0] b;
    longint unsigned p;
    b = '0;
    p = 1;
    for (int i = 1; i < DIGITS; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input logic [31:0] f, input string tag);
    int e;
    int bc;
    bus.Freq  = f;
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    e  = 1;
    bc = 0;
    while (bus.Done !== 1'b1 && e < 100) begin
      if (bus.Busy === 1'b1) bc++;
      @(negedge Clk);
      e++;
    end
    chk({tag, "_latency"}, 64'(e - 1), 64'(WIDTH));
    chk({tag, "_busycyc"}, 64'(bc), 64'(WIDTH));
    chk({tag, "_busy_at_done"}, 64'(bus.Busy), 64'(0));
    chk({tag, "_bcd"}, 64'(bus.Bcd), 64'(ref_bcd(64'(f))));
    chk({tag, "_blank"}, 64'(bus.Blank), 64'(ref_blank(64'(f))));
    @(negedge Clk);
    chk({tag, "_done_1cyc"}, 64'(bus.Done), 64'(0));
  endtask

  initial begin
    int e;
    int nd;
    logic [31:0] r;
    vectors     = 0;
    miscompares = 0;
    Reset_n     = 1'b0;
    bus.Start   = 1'b0;
    bus.Freq    = '0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", 64'(bus.Busy), 64'(0));
    chk("rst_done", 64'(bus.Done), 64'(0));
    chk("rst_bcd", 64'(bus.Bcd), 64'(0));
    chk("rst_blank", 64'(bus.Blank), 64'h3FE);
    Reset_n = 1'b1;
    @(negedge Clk);

    run_conv(32'd0, "zero");
    run_conv(32'd1234, "f1234");
    run_conv(32'hFFFF_FFFF, "fmax");
    run_conv(32'd9, "f9");
    run_conv(32'd10, "f10");
    run_conv(32'd99999, "f99999");

    // Start and new Freq while busy must be ignored
    bus.Freq  = 32'd100;
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    e = 1;
    while (bus.Done !== 1'b1 && e < 100) begin
      if (e == 5) begin
        bus.Freq  = 32'd999;
        bus.Start = 1'b1;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge Clk);
      e++;
    end
    bus.Start = 1'b0;
    chk("ign_latency", 64'(e - 1), 64'(WIDTH));
    chk("ign_bcd", 64'(bus.Bcd), 64'(ref_bcd(100)));
    chk("ign_blank", 64'(bus.Blank), 64'(ref_blank(100)));
    nd = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) nd++;
    end
    chk("ign_no_second", 64'(nd), 64'(0));

    // Start held high: back-to-back every WIDTH+1 clocks
    bus.Freq  = 32'd50;
    bus.Start = 1'b1;
    @(negedge Clk);
    e = 1;
    while (bus.Done !== 1'b1 && e < 100) begin
      @(negedge Clk);
      e++;
    end
    chk("b2b_lat0", 64'(e - 1), 64'(WIDTH));
    chk("b2b_bcd0", 64'(bus.Bcd), 64'(ref_bcd(50)));
    chk("b2b_blank0", 64'(bus.Blank), 64'h3FC);
    bus.Freq = 32'd60;
    @(negedge Clk);
    e = 1;
    while (bus.Done !== 1'b1 && e < 100) begin
      if (e == 10) chk("b2b_hold", 64'(bus.Bcd), 64'(ref_bcd(50)));
      @(negedge Clk);
      e++;
    end
    bus.Start = 1'b0;
    chk("b2b_period", 64'(e), 64'(WIDTH + 1));
    chk("b2b_bcd1", 64'(bus.Bcd), 64'(ref_bcd(60)));
    chk("b2b_blank1", 64'(bus.Blank), 64'h3FC);
    @(negedge Clk);

    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      if (i[0]) r = r >> $urandom_range(31, 0);
      run_conv(r, $sformatf("rnd%0d", i));
    end

    // Reset and Start on the same edge: reset wins
    Reset_n   = 1'b0;
    bus.Start = 1'b1;
    bus.Freq  = 32'd5;
    @(negedge Clk);
    Reset_n   = 1'b1;
    bus.Start = 1'b0;
    chk("rst_start_busy", 64'(bus.Busy), 64'(0));
    chk("rst_start_bcd", 64'(bus.Bcd), 64'(0));
    @(negedge Clk);
    chk("rst_start_busy2", 64'(bus.Busy), 64'(0));

    // Reset mid-conversion aborts without Done
    run_conv(32'd4321, "pre_abort");
    bus.Freq  = 32'd777;
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    chk("abort_busy", 64'(bus.Busy), 64'(0));
    chk("abort_done", 64'(bus.Done), 64'(0));
    chk("abort_bcd", 64'(bus.Bcd), 64'(0));
    chk("abort_blank", 64'(bus.Blank), 64'h3FE);
    Reset_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'(0));
    run_conv(32'd777, "f777");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_bcd_converter.md
Name: freq_bcd_converter

Overview:
Downstream consumer of the frequency counter's 32-bit binary Freq result. Converts one sampled Freq value into packed BCD digits by sequential shift-add-3 (double dabble), one bit per clock. Also produces a leading-zero blank mask for the seven-segment display driver that follows it. Start/Busy/Done handshake, so the counter's update strobe (or a display refresh tick) can trigger a conversion.

Parameters:
WIDTH, 32, width of binary input Freq.
DIGITS, 10, number of BCD digits produced. Must satisfy 10^DIGITS > 2^WIDTH - 1; the default covers 4294967295.

Ports:
Clk      input   1           system clock, all logic on rising edge
Reset_n  input   1           synchronous, active-low reset
Start    input   1           request conversion of current Freq
Freq     input   WIDTH       binary frequency from frequency counter
Busy     output  1           conversion in progress
Done     output  1           one-cycle pulse: Bcd/Blank just updated
Bcd      output  4*DIGITS    packed BCD, digit i at bits [4i+3:4i], digit 0 = units
Blank    output  DIGITS      bit i = 1 when digit i is a leading zero

Behaviour:
- Reset: sampled only on the rising edge while Reset_n = 0. All outputs are registered.
- Reset values:
  - Busy = 0, Done = 0, Bcd = 0.
  - Blank = all ones except bit 0 (default 10'h3FE).
  - State = IDLE; internal shift, scratch and bit-counter registers cleared.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with Start = 1: capture Freq into the shift register, clear scratch BCD, set bit counter = 0, set Busy = 1, go to SHIFT.
  - Start = 0: remain in IDLE.
- SHIFT, each edge:
  - Every scratch digit >= 5 gets +3 (all digits corrected in parallel, combinationally).
  - Then {scratch, shift} shifts left by 1, with the shift MSB entering scratch bit 0.
  - Bit counter increments.
- Last shift (counter = WIDTH-1), on that same edge:
  - Bcd <= final scratch value; Blank <= computed mask.
  - Done <= 1, Busy <= 0, state -> IDLE.
- Latency: Start sampled at edge k -> Busy high in cycles k+1..k+WIDTH. Bcd/Blank valid and Done = 1 in the cycle after edge k+WIDTH (exactly WIDTH clocks after the Start edge).
- Done: high for exactly one cycle, cleared on the next edge unconditionally.
- Bcd/Blank hold their values until the next completed conversion. They never show partial results.
- Start while Busy = 1: ignored, with no queuing.
- Start during the Done cycle: accepted (state is IDLE). This gives back-to-back conversions every WIDTH+1 clocks; Bcd holds the prior result until the new one completes.
- Freq changes while Busy: no effect. Only the value captured at the Start edge is converted.
- Blank:
  - Bit i (i >= 1) = 1 when digit i and all higher digits are zero.
  - Bit 0 is always 0.
- Reset_n = 0 mid-conversion: conversion aborted, all outputs return to reset values on that edge, and no Done pulse is generated.
- Reset_n and Start both active on the same edge: reset wins.
- Arithmetic: per-digit add-3 is 4-bit with no carry out (the input is always <= 9 before correction). The scratch register is 4*DIGITS bits, and no overflow is possible under the DIGITS constraint.

Test Plan:
- Reset: Reset_n=0 for 2 cycles -> Busy=0, Done=0, Bcd=40'h0, Blank=10'h3FE.
- Freq=0, Start pulse -> Done exactly 32 cycles after Start edge; Bcd=40'h0, Blank=10'h3FE, Busy high for exactly 32 cycles.
- Freq=1234, Start -> Bcd=40'h0000001234, Blank=10'h3F0. Then Freq=4294967295, Start -> Bcd=40'h4294967295, Blank=10'h000.
- Freq=100, Start; change Freq to 999 and pulse Start 5 cycles later while Busy -> single Done, Bcd=40'h0000000100, no second conversion.
- Start held high continuously with Freq=50 then 60 -> Done every 33 cycles; results 40'h50 then 40'h60 with matching Blank values (10'h3FC).
- Freq=777, Start; Reset_n=0 at cycle 10 of SHIFT -> no Done; outputs at reset values. After release, Start -> Bcd=40'h0000000777.
